cdc_sync_filter: RTL and testbench

- Parametrised multi-channel input synchroniser with a per-channel debounce/glitch filter and edge-pulse outputs.
- Brings asynchronous level signals into the `clk` domain. Typical sources: Apple II bus strobes, switches, slow status lines.
- Each bit passes through a DEPTH-stage flop chain, then must hold stable for FILTER consecutive cycles before the output updates.
- Channels are independent bits. The block gives no multi-bit coherency guarantee.

---
 rtl/cdc_sync_filter.sv | 125 ++++++++++++
 tb/tb_cdc_sync_filter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cdc_sync_filter.sv
// cdc_sync_filter
// Multi-channel level synchroniser. Each channel has a DEPTH-stage flop chain
// and a glitch filter: the synchronised level must disagree with the output for
// FILTER consecutive cycles before the output follows it.
// Channels are independent bits. The block gives no multi-bit coherency.
// Optional macro CDC_SYNC_EDGE_EN: when defined, adds registered one-cycle
// rise/fall pulses per channel and a combined 'changed' flag. When undefined,
// rise/fall/changed are tied to zero and 'o' timing is unchanged.
module cdc_sync_filter #(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 3,
   parameter int               FILTER    = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i,
   output logic [WIDTH-1:0] o,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   // Counter only needs to reach FILTER-1; keep at least one bit so FILTER=1 elaborates.
   localparam int            CW      = (FILTER > 1) ? $clog2(FILTER) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(FILTER - 1);

   // Reject parameter values that would make the chain or filter meaningless.
   generate
      if (DEPTH < 2) begin : g_bad_depth
         $error("cdc_sync_filter: DEPTH must be >= 2");
      end
      if (FILTER < 1) begin : g_bad_filter
         $error("cdc_sync_filter: FILTER must be >= 1");
      end
   endgenerate

   (* keep = "true" *) logic [WIDTH-1:0] stage_reg [DEPTH];
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] o_reg;
   logic [WIDTH-1:0] o_next;

   assign sync = stage_reg[DEPTH-1];
   assign o    = o_reg;

   // Synchroniser chain: shift the raw inputs through DEPTH flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            stage_reg[k] <= RESET_VAL;
         end
      end else begin
         stage_reg[0] <= i;
         for (int k = 1; k < DEPTH; k++) begin
            stage_reg[k] <= stage_reg[k-1];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_chan
         logic [CW-1:0] cnt_reg;
         logic [CW-1:0] cnt_next;
         logic          differ;
         logic          done;

         assign differ = sync[gi] ^ o_reg[gi];
         assign done   = differ && (cnt_reg == CNT_MAX);

         // Count consecutive disagreeing cycles; any agreement or an accepted change restarts from 0.
         always_comb begin
            cnt_next = '0;
            if (differ && !done) begin
               cnt_next = cnt_reg + CW'(1);
            end
         end

         // Per-channel stability counter.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_reg <= '0;
            end else begin
               cnt_reg <= cnt_next;
            end
         end

         assign o_next[gi] = done ? sync[gi] : o_reg[gi];
      end
   endgenerate

   // Filtered output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_reg <= RESET_VAL;
      end else begin
         o_reg <= o_next;
      end
   end

`ifdef CDC_SYNC_EDGE_EN
   logic [WIDTH-1:0] rise_reg;
   logic [WIDTH-1:0] fall_reg;

   // Edge pulses registered alongside o so they line up with the new output value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_reg <= '0;
         fall_reg <= '0;
      end else begin
         rise_reg <= o_next & ~o_reg;
         fall_reg <= ~o_next & o_reg;
      end
   end

   assign rise    = rise_reg;
   assign fall    = fall_reg;
   assign changed = |(rise_reg | fall_reg);
`else
   assign rise    = '0;
   assign fall    = '0;
   assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_sync_filter.sv
// Testbench for cdc_sync_filter: table-driven vectors through a scoreboard queue,
// plus hand-written reset sequences. Pulse expectations follow CDC_SYNC_EDGE_EN.
module tb_cdc_sync_filter;

`ifdef CDC_SYNC_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] i;
      logic [7:0] o;
      logic [7:0] rise;
      logic [7:0] fall;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n_a, rst_n_b;
   logic [7:0] i_a, i_b, o_a, o_b, rise_a, rise_b, fall_a, fall_b;
   logic       changed_a, changed_b;

   vec_t sb[$];
   vec_t lat_tbl[$], gl3_tbl[$], gl4_tbl[$], sim_tbl[$], mid_pre[$], mid_post[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   cdc_sync_filter #(.WIDTH(8), .DEPTH(3), .FILTER(4), .RESET_VAL(8'h00)) dut_a (
      .clk(clk), .rst_n(rst_n_a), .i(i_a), .o(o_a),
      .rise(rise_a), .fall(fall_a), .changed(changed_a)
   );

   cdc_sync_filter #(.WIDTH(8), .DEPTH(3), .FILTER(4), .RESET_VAL(8'hA5)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .i(i_b), .o(o_b),
      .rise(rise_b), .fall(fall_b), .changed(changed_b)
   );

   function automatic vec_t mk(input logic [7:0] vi, input logic [7:0] vo,
                               input logic [7:0] vr, input logic [7:0] vf);
      vec_t v;
      v.i = vi; v.o = vo; v.rise = vr; v.fall = vf;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] ao, input logic [7:0] ar,
                        input logic [7:0] af, input logic ac, input vec_t e);
      logic [7:0] er, ef;
      logic       ec;
      er = EDGE_EN ? e.rise : 8'h00;
      ef = EDGE_EN ? e.fall : 8'h00;
      ec = |(er | ef);
      tests++;
      if (ao !== e.o || ar !== er || af !== ef || ac !== ec) begin
         fails++;
         $display("FAIL %s: got o=%h rise=%h fall=%h changed=%b, expected o=%h rise=%h fall=%h changed=%b",
                  name, ao, ar, af, ac, e.o, er, ef, ec);
      end else begin
         $display("[TB] %s ok: o=%h rise=%h fall=%h changed=%b", name, ao, ar, af, ac);
      end
   endtask

   // Drive one input vector, queue its expectation, clock once, then pop and compare.
   task automatic apply(input bit sel, input string name, input vec_t v);
      vec_t e;
      if (sel) i_b = v.i; else i_a = v.i;
      sb.push_back(v);
      tick();
      e = sb.pop_front();
      if (sel) check(name, o_b, rise_b, fall_b, changed_b, e);
      else     check(name, o_a, rise_a, fall_a, changed_a, e);
   endtask

   task automatic reset_a();
      rst_n_a = 1'b0;
      i_a     = 8'h00;
      tick();
      tick();
      check("reset a", o_a, rise_a, fall_a, changed_a, mk(8'h00, 8'h00, 8'h00, 8'h00));
      rst_n_a = 1'b1;
   endtask

   initial begin
      // Latency: i[0] rises before edge 1, o[0] follows at edge 7.
      for (int k = 0; k < 6; k++) lat_tbl.push_back(mk(8'h01, 8'h00, 8'h00, 8'h00));
      lat_tbl.push_back(mk(8'h01, 8'h01, 8'h01, 8'h00));
      lat_tbl.push_back(mk(8'h01, 8'h01, 8'h00, 8'h00));
      // 3-cycle glitch on i[2] is swallowed.
      for (int k = 0; k < 3; k++) gl3_tbl.push_back(mk(8'h05, 8'h01, 8'h00, 8'h00));
      for (int k = 0; k < 6; k++) gl3_tbl.push_back(mk(8'h01, 8'h01, 8'h00, 8'h00));
      // 4-cycle pulse on i[2] passes: rise at edge 7, fall at edge 11.
      for (int k = 0; k < 4; k++) gl4_tbl.push_back(mk(8'h05, 8'h01, 8'h00, 8'h00));
      for (int k = 0; k < 2; k++) gl4_tbl.push_back(mk(8'h01, 8'h01, 8'h00, 8'h00));
      gl4_tbl.push_back(mk(8'h01, 8'h05, 8'h04, 8'h00));
      for (int k = 0; k < 3; k++) gl4_tbl.push_back(mk(8'h01, 8'h05, 8'h00, 8'h00));
      gl4_tbl.push_back(mk(8'h01, 8'h01, 8'h00, 8'h04));
      gl4_tbl.push_back(mk(8'h01, 8'h01, 8'h00, 8'h00));
      // Four channels rise together, then fall together.
      for (int k = 0; k < 6; k++) sim_tbl.push_back(mk(8'h0F, 8'h00, 8'h00, 8'h00));
      sim_tbl.push_back(mk(8'h0F, 8'h0F, 8'h0F, 8'h00));
      sim_tbl.push_back(mk(8'h0F, 8'h0F, 8'h00, 8'h00));
      for (int k = 0; k < 6; k++) sim_tbl.push_back(mk(8'h00, 8'h0F, 8'h00, 8'h00));
      sim_tbl.push_back(mk(8'h00, 8'h00, 8'h00, 8'h0F));
      sim_tbl.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00));
      // Mid-count reset on i[5]: full latency restarts after release.
      for (int k = 0; k < 4; k++) mid_pre.push_back(mk(8'h20, 8'h00, 8'h00, 8'h00));
      for (int k = 0; k < 6; k++) mid_post.push_back(mk(8'h20, 8'h00, 8'h00, 8'h00));
      mid_post.push_back(mk(8'h20, 8'h20, 8'h20, 8'h00));
      mid_post.push_back(mk(8'h20, 8'h20, 8'h00, 8'h00));

      rst_n_a = 1'b0;
      rst_n_b = 1'b0;
      i_a     = 8'h00;
      i_b     = 8'hFF;

      // Reset value held while inputs are all ones.
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("reset b hold %0d", k), o_b, rise_b, fall_b, changed_b,
               mk(8'hFF, 8'hA5, 8'h00, 8'h00));
      end
      rst_n_b = 1'b1;
      for (int k = 0; k < 6; k++) apply(1'b1, $sformatf("b release e%0d", k + 1), mk(8'hFF, 8'hA5, 8'h00, 8'h00));
      apply(1'b1, "b release e7", mk(8'hFF, 8'hFF, 8'h5A, 8'h00));
      apply(1'b1, "b release e8", mk(8'hFF, 8'hFF, 8'h00, 8'h00));

      // Asynchronous reset between edges restores RESET_VAL immediately.
      #3;
      rst_n_b = 1'b0;
      #1;
      check("b async reset", o_b, rise_b, fall_b, changed_b, mk(8'hFF, 8'hA5, 8'h00, 8'h00));
      i_b = 8'hA5;
      tick();
      check("b in reset", o_b, rise_b, fall_b, changed_b, mk(8'hA5, 8'hA5, 8'h00, 8'h00));
      rst_n_b = 1'b1;
      for (int k = 0; k < 10; k++) apply(1'b1, $sformatf("b quiet e%0d", k + 1), mk(8'hA5, 8'hA5, 8'h00, 8'h00));

      reset_a();
      foreach (lat_tbl[k]) apply(1'b0, $sformatf("latency e%0d", k + 1), lat_tbl[k]);
      foreach (gl3_tbl[k]) apply(1'b0, $sformatf("glitch3 e%0d", k + 1), gl3_tbl[k]);
      foreach (gl4_tbl[k]) apply(1'b0, $sformatf("pulse4 e%0d", k + 1), gl4_tbl[k]);

      reset_a();
      foreach (sim_tbl[k]) apply(1'b0, $sformatf("simul e%0d", k + 1), sim_tbl[k]);

      reset_a();
      foreach (mid_pre[k]) apply(1'b0, $sformatf("midcount pre e%0d", k + 1), mid_pre[k]);
      rst_n_a = 1'b0;
      tick();
      check("midcount in reset", o_a, rise_a, fall_a, changed_a, mk(8'h20, 8'h00, 8'h00, 8'h00));
      rst_n_a = 1'b1;
      foreach (mid_post[k]) apply(1'b0, $sformatf("midcount post e%0d", k + 1), mid_post[k]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
